// File: rtl/if_unit_if.sv
// ============================================================================
// if_unit_if : instruction-memory fetch bus (request/address out, data/ready in)
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface if_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

`default_nettype wire

// File: rtl/if_unit.sv
// ============================================================================
// if_unit  : instruction fetch stage with IF/ID register, stall and redirect
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_unit #(
  parameter logic [15:0] PC_RESET   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'hF000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  if_unit_if.master   imem,
  output logic [15:0] instr_out,
  output logic        if_valid,
  output logic [3:0]  cntrl_opcode,
  output logic [3:0]  branch_cond,
  output logic [3:0]  load_save_reg,
  output logic [3:0]  reg_rs,
  output logic [3:0]  reg_rt_arith,
  output logic [3:0]  arith_imm,
  output logic [7:0]  load_save_imm,
  output logic [11:0] call_target,
  output logic [15:0] PC_out,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic        req;
  logic        accept;
  logic [15:0] pc_inc;

  // Request is combinational so a zero-wait memory sustains one fetch per cycle.
  always_comb begin
    req = 1'b0;
    case (state)
      FETCH:   req = ~stall;
      WAIT:    req = 1'b1;
      default: req = 1'b0;
    endcase
    if (rst) begin
      req = 1'b0;
    end
  end

  assign accept = req & imem.imem_ready;
  assign pc_inc = pc + 16'd1;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_RESET;
      instr_out <= NOP_INSTR;
      if_valid  <= 1'b0;
      PC_out    <= 16'h0000;
      halted    <= 1'b0;
      state     <= FETCH;
    end else if (redirect_en) begin
      pc        <= redirect_pc;
      instr_out <= NOP_INSTR;
      if_valid  <= 1'b0;
      halted    <= 1'b0;
      state     <= FETCH;
    end else if (stall) begin
      // Everything holds; a response landing in WAIT is dropped and re-requested.
      pc        <= pc;
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (accept) begin
            instr_out <= imem.imem_rdata;
            if_valid  <= 1'b1;
            PC_out    <= pc_inc;
            pc        <= pc_inc;
            if (imem.imem_rdata[15:12] == HLT_OPCODE) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state  <= FETCH;
            end
          end else begin
            instr_out <= NOP_INSTR;
            if_valid  <= 1'b0;
            state     <= WAIT;
          end
        end
        default: begin
          instr_out <= NOP_INSTR;
          if_valid  <= 1'b0;
          state     <= HALT;
        end
      endcase
    end
  end

  assign cntrl_opcode  = instr_out[15:12];
  assign branch_cond   = instr_out[11:8];
  assign load_save_reg = instr_out[11:8];
  assign reg_rs        = instr_out[7:4];
  assign reg_rt_arith  = instr_out[3:0];
  assign arith_imm     = instr_out[3:0];
  assign load_save_imm = instr_out[7:0];
  assign call_target   = instr_out[11:0];

endmodule

`default_nettype wire

// File: tb/tb_if_unit.sv
// ============================================================================
// tb_if_unit : directed bench for if_unit with a per-cycle reference model
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_if_unit;

  localparam logic [15:0] NOP = 16'hF000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic [15:0] instr_out;
  logic        if_valid;
  logic [3:0]  cntrl_opcode, branch_cond, load_save_reg, reg_rs, reg_rt_arith, arith_imm;
  logic [7:0]  load_save_imm;
  logic [11:0] call_target;
  logic [15:0] PC_out;
  logic        halted;

  if_unit_if bus ();

  if_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .imem          (bus.master),
    .instr_out     (instr_out),
    .if_valid      (if_valid),
    .cntrl_opcode  (cntrl_opcode),
    .branch_cond   (branch_cond),
    .load_save_reg (load_save_reg),
    .reg_rs        (reg_rs),
    .reg_rt_arith  (reg_rt_arith),
    .arith_imm     (arith_imm),
    .load_save_imm (load_save_imm),
    .call_target   (call_target),
    .PC_out        (PC_out),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a few fixed words, everything else opcode 2 with the low address bits.
  logic [15:0] mem [int];
  function automatic logic [15:0] memrd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {4'h2, a[11:0]};
  endfunction

  // Reference model: what decode should see, derived from the fetch rules.
  bit          m_init    = 0;
  logic [15:0] m_pc      = 16'h0000;
  logic [15:0] m_instr   = NOP;
  logic        m_valid   = 1'b0;
  logic [15:0] m_pcout   = 16'h0000;
  logic        m_halt    = 1'b0;
  logic        m_waiting = 1'b0;

  function automatic logic exp_req();
    return !rst && !m_halt && (m_waiting || !stall);
  endfunction

  always @(posedge clk) begin
    logic took;
    took = exp_req() && bus.imem_ready;
    if (rst) begin
      m_init = 1; m_pc = 16'h0000; m_instr = NOP; m_valid = 0;
      m_pcout = 16'h0000; m_halt = 0; m_waiting = 0;
    end else if (redirect_en) begin
      m_pc = redirect_pc; m_instr = NOP; m_valid = 0; m_halt = 0; m_waiting = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_halt) begin
      m_instr = NOP; m_valid = 0;
    end else if (took) begin
      m_instr = bus.imem_rdata; m_valid = 1;
      m_pc = m_pc + 16'd1; m_pcout = m_pc;
      m_halt = (bus.imem_rdata[15:12] == 4'hF); m_waiting = 0;
    end else begin
      m_instr = NOP; m_valid = 0; m_waiting = 1;
    end
  end

  // Compare process: every negedge once the model has seen a reset.
  always @(negedge clk) begin
    if (m_init) begin
      chk("instr_out", instr_out, m_instr);
      chk("if_valid", {15'd0, if_valid}, {15'd0, m_valid});
      chk("PC_out", PC_out, m_pcout);
      chk("halted", {15'd0, halted}, {15'd0, m_halt});
      chk("imem_req", {15'd0, bus.imem_req}, {15'd0, exp_req()});
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("fields", {cntrl_opcode, branch_cond, reg_rs, reg_rt_arith}, m_instr);
      chk("fields2", {load_save_reg, arith_imm, load_save_imm},
          {m_instr[11:8], m_instr[3:0], m_instr[7:0]});
      chk("call_target", {4'h0, call_target}, {4'h0, m_instr[11:0]});
    end
  end

  task automatic cyc(input logic r, input logic s, input logic re, input logic [15:0] rp,
                     input logic rdy);
    rst = r; stall = s; redirect_en = re; redirect_pc = rp; bus.imem_ready = rdy;
    @(posedge clk);
    #1;
    bus.imem_rdata = memrd(bus.imem_addr);
  endtask

  initial begin
    mem[0]     = 16'h1234;
    mem[1]     = 16'h5678;
    mem[32'hFFFF] = 16'hF000;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 16'h0000;

    // Reset
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_instr", instr_out, 16'hF000);
    chk("rst_valid", {15'd0, if_valid}, 16'd0);
    chk("rst_pcout", PC_out, 16'h0000);
    chk("rst_req", {15'd0, bus.imem_req}, 16'd0);

    // Zero-wait fetches
    cyc(0, 0, 0, 0, 1);
    chk("e1_instr", instr_out, 16'h1234);
    chk("e1_pcout", PC_out, 16'h0001);
    chk("e1_fields", {cntrl_opcode, reg_rs, reg_rt_arith, 3'd0, if_valid}, 16'h1341);
    cyc(0, 0, 0, 0, 1);
    chk("e2_instr", instr_out, 16'h5678);
    chk("e2_pcout", PC_out, 16'h0002);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("pc5", bus.imem_addr, 16'h0005);

    // Three wait cycles at pc=5
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("wait_addr", bus.imem_addr, 16'h0005);
      chk("wait_valid", {15'd0, if_valid}, 16'd0);
    end
    cyc(0, 0, 0, 0, 1);
    chk("late_instr", instr_out, 16'h2005);
    chk("late_pcout", PC_out, 16'h0006);

    // Stall after valid instruction at pc=7
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 1);
      chk("stall_instr", instr_out, 16'h2007);
      chk("stall_pcout", PC_out, 16'h0008);
      chk("stall_addr", bus.imem_addr, 16'h0008);
      chk("stall_req", {15'd0, bus.imem_req}, 16'd0);
    end
    cyc(0, 0, 0, 0, 1);
    chk("resume_instr", instr_out, 16'h2008);

    // Redirect beats stall and a ready response
    cyc(0, 1, 1, 16'h0040, 1);
    chk("redir_addr", bus.imem_addr, 16'h0040);
    chk("redir_instr", instr_out, 16'hF000);
    chk("redir_valid", {15'd0, if_valid}, 16'd0);
    cyc(0, 0, 0, 0, 1);
    chk("redir_fetch", instr_out, 16'h2040);
    chk("redir_pcout", PC_out, 16'h0041);

    // Stall while waiting drops the response
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    chk("wstall_valid", {15'd0, if_valid}, 16'd0);
    cyc(0, 0, 0, 0, 1);
    chk("wstall_fetch", instr_out, 16'h2041);

    // Halt at pc=FFFF with wrap
    cyc(0, 0, 1, 16'hFFFF, 0);
    cyc(0, 0, 0, 0, 1);
    chk("hlt_instr", instr_out, 16'hF000);
    chk("hlt_flags", {14'd0, if_valid, halted}, 16'h0003);
    chk("hlt_pcout", PC_out, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("halt_req", {15'd0, bus.imem_req}, 16'd0);
      chk("halt_valid", {15'd0, if_valid}, 16'd0);
    end
    cyc(0, 0, 1, 16'h0010, 1);
    chk("unhalt", {15'd0, halted}, 16'd0);
    cyc(0, 0, 0, 0, 1);
    chk("unhalt_fetch", instr_out, 16'h2010);

    // Reset in the middle of a wait; the late ready is ignored
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("wrst_addr", bus.imem_addr, 16'h0000);
    chk("wrst_flags", {14'd0, if_valid, halted}, 16'h0000);
    chk("wrst_instr", instr_out, 16'hF000);
    cyc(0, 0, 0, 0, 0);
    chk("wrst_valid", {15'd0, if_valid}, 16'd0);
    cyc(0, 0, 0, 0, 1);
    chk("wrst_fetch", instr_out, 16'h1234);
    cyc(0, 0, 0, 0, 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
